read_queue_manager: RTL and testbench

Per-priority descriptor queue and address sequencer that feeds the read arbiter. The write path pushes one descriptor (start address, length in words) per stored packet. The arbiter selects a priority one-hot and holds a read request. This block then pops that priority's oldest descriptor and streams consecutive SRAM word addresses, flagging the final word with `last`. It also drives the per-priority `prepared` vector the arbiter schedules from.

---
 rtl/read_queue_manager_pkg.sv | 30 +++
 rtl/read_queue_manager_desc_fifo.sv | 77 +++++++
 rtl/read_queue_manager.sv | 195 +++++++++++++++++++
 tb/tb_read_queue_manager.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/read_queue_manager_pkg.sv
// ----------------------------------------------------------------------------
// read_queue_manager_pkg
// Shared definitions for the read queue manager slice: default parameter
// values, the sequencer state encoding and the descriptor width helper.
// A descriptor is packed as {start_address, length_in_words}.
// ----------------------------------------------------------------------------
package read_queue_manager_pkg;

    localparam int DEF_NUM_OF_PRIORITIES = 8;
    localparam int DEF_PRIORITY_WIDTH    = 3;
    localparam int DEF_ADDRESS_WIDTH     = 12;
    localparam int DEF_LEN_WIDTH         = 6;
    localparam int DEF_QUEUE_DEPTH       = 8;
    localparam int DEF_DESC_WIDTH        = DEF_ADDRESS_WIDTH + DEF_LEN_WIDTH;

    // Sequencer states: wait for a select, pop the head descriptor,
    // emit one word address per cycle, then wait for the arbiter to let go.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        STREAM = 2'd2,
        DRAIN  = 2'd3
    } seqState_t;

    // Width of one packed descriptor for a given address/length split.
    function automatic int descWidth(input int addrW, input int lenW);
        return addrW + lenW;
    endfunction

endpackage

// File: rtl/read_queue_manager_desc_fifo.sv
// ----------------------------------------------------------------------------
// desc_fifo
// Single-priority circular descriptor FIFO. Pushes are ignored when full and
// pops are ignored when empty; a push and a pop in the same cycle both take
// effect and leave the occupancy unchanged. The head entry is presented
// combinationally on rdata_o.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset (pointers and occupancy cleared)
//   push_i   write wdata_i at the tail
//   pop_i    drop the head entry
//   wdata_i  descriptor to store
//   rdata_o  descriptor at the head
//   full_o   occupancy equals DEPTH
//   empty_o  occupancy is zero
// ----------------------------------------------------------------------------
module desc_fifo #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wrPtr_q;
    logic [PTR_W-1:0]  rdPtr_q;
    logic [CNT_W-1:0]  count_q;
    logic              doPush;
    logic              doPop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign rdata_o = mem_q[rdPtr_q];

    // Pointers wrap naturally because DEPTH is a power of two; the separate
    // occupancy counter distinguishes full from empty when pointers meet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only ever read after being written.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/read_queue_manager.sv
// ----------------------------------------------------------------------------
// read_queue_manager
// Per-priority descriptor queues plus the SRAM read address sequencer that
// feeds the read arbiter. The write path pushes {addr, len} descriptors; the
// arbiter selects a priority (one-hot) and holds rd_request for the whole
// packet; this block pops that priority's oldest descriptor and streams
// consecutive word addresses, flagging the final one with last.
//
// Ports:
//   clk, rst         clock / asynchronous active-low reset
//   desc_vld/pri/addr/len  descriptor push from the write path
//   desc_rdy         queue addressed by desc_pri is not full
//   next_data        one-hot priority select from the arbiter
//   rd_request       held high by the arbiter for the whole transfer
//   prepared         bit i set while queue i holds a descriptor
//   address_to_read  registered SRAM word address
//   last             registered final-word flag
//   busy             a packet is being sequenced
//   err              one-cycle pulse after an illegal push or select
// ----------------------------------------------------------------------------
module read_queue_manager
    import read_queue_manager_pkg::*;
#(
    parameter int num_of_priorities = DEF_NUM_OF_PRIORITIES,
    parameter int priority_width    = DEF_PRIORITY_WIDTH,
    parameter int address_width     = DEF_ADDRESS_WIDTH,
    parameter int len_width         = DEF_LEN_WIDTH,
    parameter int queue_depth       = DEF_QUEUE_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         desc_vld,
    input  logic [priority_width-1:0]    desc_pri,
    input  logic [address_width-1:0]     desc_addr,
    input  logic [len_width-1:0]         desc_len,
    output logic                         desc_rdy,
    input  logic [num_of_priorities-1:0] next_data,
    input  logic                         rd_request,
    output logic [num_of_priorities-1:0] prepared,
    output logic [address_width-1:0]     address_to_read,
    output logic                         last,
    output logic                         busy,
    output logic                         err
);

    localparam int DescW = descWidth(address_width, len_width);

    seqState_t                    state_q;
    seqState_t                    state_d;
    logic [num_of_priorities-1:0] pushVec;
    logic [num_of_priorities-1:0] popVec;
    logic [num_of_priorities-1:0] fullVec;
    logic [num_of_priorities-1:0] emptyVec;
    logic [DescW-1:0]             headDesc [num_of_priorities];
    logic [DescW-1:0]             loadDesc;
    logic [priority_width-1:0]    priSel_q;
    logic [priority_width-1:0]    selPri;
    logic                         selOneHot;
    logic                         selValid;
    logic                         pushAccept;
    logic                         pushErr;
    logic                         selErr;
    logic                         popEn;
    logic                         streamEn;
    logic [address_width-1:0]     curAddr_q;
    logic [len_width-1:0]         remaining_q;
    logic [address_width-1:0]     addrOut_q;
    logic                         last_q;
    logic                         err_q;

    assign desc_rdy   = !fullVec[desc_pri];
    assign prepared   = ~emptyVec;
    assign pushAccept = desc_vld && desc_rdy && (desc_len != '0);
    assign pushErr    = desc_vld && (!desc_rdy || (desc_len == '0));
    assign loadDesc   = headDesc[priSel_q];

    // One FIFO per priority. Each queue only sees pushes addressed to it and
    // pops for the priority latched at select time.
    for (genvar g = 0; g < num_of_priorities; g++) begin : gQueue
        assign pushVec[g] = pushAccept && (desc_pri == priority_width'(g));
        assign popVec[g]  = popEn && (priSel_q == priority_width'(g));

        desc_fifo #(
            .DATA_W (DescW),
            .DEPTH  (queue_depth)
        ) uFifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (pushVec[g]),
            .pop_i   (popVec[g]),
            .wdata_i ({desc_addr, desc_len}),
            .rdata_o (headDesc[g]),
            .full_o  (fullVec[g]),
            .empty_o (emptyVec[g])
        );
    end

    // Validate and encode the arbiter's select. A select is only usable when
    // exactly one bit is set and that queue currently holds a descriptor.
    always_comb begin
        selPri = '0;
        for (int i = 0; i < num_of_priorities; i++) begin
            if (next_data[i]) begin
                selPri = priority_width'(i);
            end
        end
        selOneHot = (next_data != '0) && ((next_data & (next_data - 1'b1)) == '0);
        selValid  = selOneHot && ((next_data & prepared) != '0);
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. Dropping rd_request in LOAD or STREAM abandons the
    // packet; the descriptor has already left its queue and is not restored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_request && selValid) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = rd_request ? STREAM : IDLE;
            end
            STREAM: begin
                if (!rd_request) begin
                    state_d = IDLE;
                end else if (remaining_q == len_width'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_request) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded controls: pop in LOAD, advance the counters while
    // streaming, and flag a bad select seen while idle.
    always_comb begin
        busy     = (state_q != IDLE);
        popEn    = (state_q == LOAD);
        streamEn = (state_q == STREAM) && rd_request;
        selErr   = (state_q == IDLE) && rd_request && !selValid;
    end

    // Address/remaining counters and the registered outputs. The output
    // register captures the counter value of each STREAM cycle, so the first
    // address appears two edges after the select is accepted. Outside an
    // active STREAM cycle last clears and the address holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            priSel_q    <= '0;
            curAddr_q   <= '0;
            remaining_q <= '0;
            addrOut_q   <= '0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= pushErr || selErr;
            if ((state_q == IDLE) && (state_d == LOAD)) begin
                priSel_q <= selPri;
            end
            if (popEn) begin
                curAddr_q   <= loadDesc[DescW-1 -: address_width];
                remaining_q <= loadDesc[len_width-1:0];
            end else if (streamEn) begin
                curAddr_q   <= curAddr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
            if (streamEn) begin
                addrOut_q <= curAddr_q;
                last_q    <= (remaining_q == len_width'(1));
            end else begin
                last_q    <= 1'b0;
            end
        end
    end

    assign address_to_read = addrOut_q;
    assign last            = last_q;
    assign err             = err_q;

endmodule

// File: tb/tb_read_queue_manager.sv
// ----------------------------------------------------------------------------
// tb_read_queue_manager
// Directed scenarios followed by randomized pushes and selects, checked
// against a queue-based reference model of the per-priority descriptor lists.
// ----------------------------------------------------------------------------
module tb_read_queue_manager;

    logic        clk;
    logic        rst;
    logic        desc_vld;
    logic [2:0]  desc_pri;
    logic [11:0] desc_addr;
    logic [5:0]  desc_len;
    logic        desc_rdy;
    logic [7:0]  next_data;
    logic        rd_request;
    logic [7:0]  prepared;
    logic [11:0] address_to_read;
    logic        last;
    logic        busy;
    logic        err;

    logic [17:0] modelQ [8][$];
    logic [11:0] lastAddr;
    int          checkCount;
    int          errCount;

    read_queue_manager dut (
        .clk             (clk),
        .rst             (rst),
        .desc_vld        (desc_vld),
        .desc_pri        (desc_pri),
        .desc_addr       (desc_addr),
        .desc_len        (desc_len),
        .desc_rdy        (desc_rdy),
        .next_data       (next_data),
        .rd_request      (rd_request),
        .prepared        (prepared),
        .address_to_read (address_to_read),
        .last            (last),
        .busy            (busy),
        .err             (err)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] modelPrepared();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) begin
            p[i] = (modelQ[i].size() != 0);
        end
        return p;
    endfunction

    // One push cycle with checks of desc_rdy, the err pulse and prepared.
    task automatic applyStimulus(input logic [2:0] pri, input logic [11:0] addr,
                                 input logic [5:0] len);
        bit accept;
        accept    = (len != 0) && (modelQ[pri].size() < 8);
        desc_vld  = 1'b1;
        desc_pri  = pri;
        desc_addr = addr;
        desc_len  = len;
        #1;
        checkOutput("desc_rdy", desc_rdy, modelQ[pri].size() < 8);
        tick();
        desc_vld = 1'b0;
        if (accept) begin
            modelQ[pri].push_back({addr, len});
        end
        checkOutput("push_err", err, !accept);
        checkOutput("push_prepared", prepared, modelPrepared());
    endtask

    // Issue a select and follow the packet. abortAfter >= 0 drops rd_request
    // after that many addresses; coPush pushes coDesc to the selected queue
    // in the same cycle the head is popped.
    task automatic runSelect(input logic [7:0] sel, input int abortAfter,
                             input bit coPush, input logic [17:0] coDesc);
        logic [7:0]  prep;
        logic [17:0] d;
        logic [11:0] a;
        logic [11:0] expA;
        bit          legal;
        bit          coAccept;
        int          p;
        int          len;
        prep  = modelPrepared();
        legal = ($countones(sel) == 1) && ((sel & prep) != 0);
        next_data  = sel;
        rd_request = 1'b1;
        tick();
        if (!legal) begin
            rd_request = 1'b0;
            next_data  = '0;
            checkOutput("sel_err", err, 1);
            checkOutput("sel_busy", busy, 0);
            checkOutput("sel_addr_hold", address_to_read, lastAddr);
            checkOutput("sel_prepared", prepared, prep);
            tick();
            checkOutput("sel_err_clear", err, 0);
            return;
        end
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) p = i;
        end
        checkOutput("load_busy", busy, 1);
        checkOutput("load_err", err, 0);
        coAccept = coPush && (coDesc[5:0] != 0) && (modelQ[p].size() < 8);
        if (coPush) begin
            desc_vld  = 1'b1;
            desc_pri  = 3'(p);
            desc_addr = coDesc[17:6];
            desc_len  = coDesc[5:0];
            #1;
            checkOutput("copush_rdy", desc_rdy, modelQ[p].size() < 8);
        end
        d   = modelQ[p].pop_front();
        a   = d[17:6];
        len = int'(d[5:0]);
        tick();
        desc_vld = 1'b0;
        if (coAccept) begin
            modelQ[p].push_back(coDesc);
        end
        if (coPush) begin
            checkOutput("copush_err", err, !coAccept);
        end
        checkOutput("pop_prepared", prepared, modelPrepared());
        for (int k = 0; k < len; k++) begin
            if (k == abortAfter) begin
                rd_request = 1'b0;
                next_data  = '0;
                tick();
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_last", last, 0);
                checkOutput("abort_addr", address_to_read, lastAddr);
                return;
            end
            tick();
            expA = a + 12'(k);
            checkOutput("stream_addr", address_to_read, expA);
            checkOutput("stream_last", last, k == len - 1);
            checkOutput("stream_busy", busy, 1);
            lastAddr = expA;
        end
        rd_request = 1'b0;
        next_data  = '0;
        tick();
        checkOutput("drain_busy", busy, 0);
        checkOutput("drain_last", last, 0);
        checkOutput("drain_addr", address_to_read, lastAddr);
    endtask

    initial begin
        checkCount = 0;
        errCount   = 0;
        lastAddr   = '0;
        rst        = 1'b0;
        desc_vld   = 1'b0;
        desc_pri   = '0;
        desc_addr  = '0;
        desc_len   = '0;
        next_data  = '0;
        rd_request = 1'b0;
        #2;
        checkOutput("rst_rdy", desc_rdy, 1);
        checkOutput("rst_prepared", prepared, 0);
        checkOutput("rst_addr", address_to_read, 0);
        checkOutput("rst_last", last, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", err, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Basic packet on priority 2.
        applyStimulus(3'd2, 12'h100, 6'd3);
        checkOutput("prep_04", prepared, 8'h04);
        runSelect(8'b0000_0100, -1, 1'b0, '0);
        checkOutput("prep_back_0", prepared, 8'h00);

        // Address wrap.
        applyStimulus(3'd0, 12'hFFE, 6'd4);
        runSelect(8'b0000_0001, -1, 1'b0, '0);

        // Illegal push and illegal selects.
        applyStimulus(3'd1, 12'h010, 6'd0);
        applyStimulus(3'd1, 12'h020, 6'd2);
        runSelect(8'b0000_0011, -1, 1'b0, '0);
        runSelect(8'b1000_0000, -1, 1'b0, '0);
        runSelect(8'b0000_0000, -1, 1'b0, '0);
        runSelect(8'b0000_0010, -1, 1'b0, '0);

        // Fill priority 5, overflow it, and push to 6 while 5 is full.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(3'd5, 12'h500 + 12'(i * 16), 6'($urandom_range(1, 4)));
        end
        applyStimulus(3'd6, 12'h600, 6'd1);
        for (int i = 0; i < 8; i++) begin
            runSelect(8'b0010_0000, -1, 1'b0, '0);
        end
        runSelect(8'b0100_0000, -1, 1'b0, '0);

        // Abort a long packet mid-stream.
        applyStimulus(3'd4, 12'h400, 6'd10);
        runSelect(8'b0001_0000, 4, 1'b0, '0);
        checkOutput("abort_consumed", prepared, modelPrepared());

        // Simultaneous push and pop on priority 3.
        applyStimulus(3'd3, 12'h300, 6'd2);
        runSelect(8'b0000_1000, -1, 1'b1, {12'h3A0, 6'd3});
        runSelect(8'b0000_1000, -1, 1'b0, '0);

        // Asynchronous reset in the middle of a packet.
        applyStimulus(3'd1, 12'h7F0, 6'd10);
        applyStimulus(3'd6, 12'h123, 6'd5);
        next_data  = 8'b0000_0010;
        rd_request = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_addr", address_to_read, 0);
        checkOutput("arst_last", last, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_prepared", prepared, 0);
        checkOutput("arst_rdy", desc_rdy, 1);
        checkOutput("arst_err", err, 0);
        rd_request = 1'b0;
        next_data  = '0;
        for (int i = 0; i < 8; i++) modelQ[i].delete();
        lastAddr = '0;
        tick();
        rst = 1'b1;
        tick();

        // Randomized mix of pushes and selects.
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 9) < 6) begin
                applyStimulus(3'($urandom_range(0, 7)), 12'($urandom),
                              ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 12)));
            end else begin
                logic [7:0] sel;
                int         ab;
                sel = ($urandom_range(0, 3) == 0) ? 8'($urandom) : (8'd1 << $urandom_range(0, 7));
                ab  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
                runSelect(sel, ab, 1'b0, '0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
